eka_ifetch: RTL and testbench

// - Instruction-fetch stage directly upstream of the Eka single-cycle core.
// - Turns the core's combinational inst_addr into a req/ack fetch on a variable-latency memory port.
// - Returns instruction + inst_valid; a one-word fetch buffer gives zero-wait hits on a re-presented address.
// - Core holds PC while inst_valid=0, so a miss stalls the core until the fill completes.

---
 rtl/eka_ifetch.sv | 230 +++++++++++++++++++++++
 tb/tb_eka_ifetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/eka_ifetch.sv
// Eka instruction-fetch stage: one-word fetch buffer in front of a req/ack memory port.
// Define EKA_IFETCH_PREFETCH_EN to add a sequential next-word prefetch entry.
module eka_ifetch #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  fetch_err
);

  localparam logic [31:0]           Nop       = 32'h0000_0013;
  localparam logic [7:0]            Timeout   = 8'(FETCH_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] WordMask  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(4);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  fetch_err_q, fetch_err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  buf_v_q, buf_v_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]           buf_data_q, buf_data_d;

  logic [ADDR_WIDTH-1:0] inst_word;
  logic                  buf_hit;
  logic                  hit;

  // Tags are kept as full word addresses; the low two bits are always zero.
  assign inst_word = inst_addr & WordMask;
  assign buf_hit   = buf_v_q && (buf_addr_q == inst_word);

`ifdef EKA_IFETCH_PREFETCH_EN
  logic                  pf_v_q, pf_v_d;
  logic [ADDR_WIDTH-1:0] pf_addr_q, pf_addr_d;
  logic [31:0]           pf_data_q, pf_data_d;
  logic                  req_pf_q, req_pf_d;
  logic                  pf_pend_q, pf_pend_d;
  logic [ADDR_WIDTH-1:0] pf_next_q, pf_next_d;
  logic                  pf_hit;
  logic                  pf_copy;
  logic                  next_buffered;

  assign pf_hit        = pf_v_q && (pf_addr_q == inst_word);
  assign hit           = buf_hit || pf_hit;
  assign next_buffered = (buf_v_q && (buf_addr_q == pf_next_q)) ||
                         (pf_v_q && (pf_addr_q == pf_next_q));
  // Promote a pf hit unless a demand fill is writing the demand entry this cycle.
  assign pf_copy       = pf_hit && !buf_hit && !flush &&
                         !((state_q == StWait) && mem_ack && !req_pf_q);

  assign instruction = !inst_valid ? Nop : (buf_hit ? buf_data_q : pf_data_q);
`else
  assign hit         = buf_hit;
  assign instruction = inst_valid ? buf_data_q : Nop;
`endif

  assign inst_valid = hit && !flush;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fetch_err  = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fetch_err_d = 1'b0;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    buf_v_d     = buf_v_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
`ifdef EKA_IFETCH_PREFETCH_EN
    pf_v_d      = pf_v_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    req_pf_d    = req_pf_q;
    pf_pend_d   = pf_pend_q;
    pf_next_d   = pf_next_q;

    if (pf_copy) begin
      buf_v_d    = 1'b1;
      buf_addr_d = pf_addr_q;
      buf_data_d = pf_data_q;
      pf_v_d     = 1'b0;
      pf_pend_d  = 1'b1;
      pf_next_d  = pf_addr_q + WordBytes;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (!flush) begin
          if (!hit) begin
            state_d    = StWait;
            mem_req_d  = 1'b1;
            mem_addr_d = inst_word;
            cnt_d      = '0;
            drop_d     = 1'b0;
`ifdef EKA_IFETCH_PREFETCH_EN
            req_pf_d   = 1'b0;
`endif
          end
`ifdef EKA_IFETCH_PREFETCH_EN
          else if (pf_pend_q && !pf_copy) begin
            pf_pend_d = 1'b0;
            if (!next_buffered) begin
              state_d    = StWait;
              mem_req_d  = 1'b1;
              mem_addr_d = pf_next_q;
              cnt_d      = '0;
              drop_d     = 1'b0;
              req_pf_d   = 1'b1;
            end
          end
`endif
        end
      end
      StWait: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
`ifdef EKA_IFETCH_PREFETCH_EN
          if (!drop_q && req_pf_q) begin
            pf_v_d    = 1'b1;
            pf_addr_d = mem_addr_q;
            pf_data_d = mem_rdata;
          end else if (!drop_q) begin
            buf_v_d    = 1'b1;
            buf_addr_d = mem_addr_q;
            buf_data_d = mem_rdata;
            pf_pend_d  = 1'b1;
            pf_next_d  = mem_addr_q + WordBytes;
          end
`else
          if (!drop_q) begin
            buf_v_d    = 1'b1;
            buf_addr_d = mem_addr_q;
            buf_data_d = mem_rdata;
          end
`endif
        end else if (cnt_q + 8'd1 == Timeout) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
`ifdef EKA_IFETCH_PREFETCH_EN
          fetch_err_d = !req_pf_q;
`else
          fetch_err_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        // The bus handshake still completes after a flush, but its data is stale.
        if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase

    if (flush) begin
      buf_v_d = 1'b0;
`ifdef EKA_IFETCH_PREFETCH_EN
      pf_v_d    = 1'b0;
      pf_pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      buf_v_q     <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_err_q <= fetch_err_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      buf_v_q     <= buf_v_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

`ifdef EKA_IFETCH_PREFETCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
      pf_data_q <= '0;
      req_pf_q  <= 1'b0;
      pf_pend_q <= 1'b0;
      pf_next_q <= '0;
    end else begin
      pf_v_q    <= pf_v_d;
      pf_addr_q <= pf_addr_d;
      pf_data_q <= pf_data_d;
      req_pf_q  <= req_pf_d;
      pf_pend_q <= pf_pend_d;
      pf_next_q <= pf_next_d;
    end
  end
`endif

endmodule

// File: tb/tb_eka_ifetch.sv
// Bench for eka_ifetch: directed scenarios, then random traffic against a transaction-level model.
module tb_eka_ifetch;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        flush;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  eka_ifetch #(
    .ADDR_WIDTH   (32),
    .FETCH_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_addr  (inst_addr),
    .flush      (flush),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Model: one buffered word plus at most one outstanding request with its age.
  logic        m_v, m_busy, m_drop, m_err, m_hit, m_fl, m_ack;
  logic [31:0] m_addr, m_req, m_word;
  int          m_age, m_lat;
  logic [31:0] addr_tab [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104,
                                32'hFFFF_FFF8, 32'hFFFF_FFFC};

  initial begin
    reset = 1'b1; inst_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk); #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_nop", instruction, NOP);

    // First fetch of 0x0, ack in the third request cycle.
    reset = 1'b0; #1;
    chk("miss0_valid", 32'(inst_valid), 32'd0);
    tick(); #1;
    chk("req0", 32'(mem_req), 32'd1);
    chk("req0_addr", mem_addr, 32'h0);
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093; #1;
    chk("req0_hold", 32'(mem_req), 32'd1);
    tick();
    mem_ack = 1'b0; #1;
    chk("fill0_valid", 32'(inst_valid), 32'd1);
    chk("fill0_data", instruction, 32'h0050_0093);
    chk("fill0_req", 32'(mem_req), 32'd0);

    // Held address keeps hitting; a stray ack while idle is ignored.
    for (int i = 0; i < 10; i++) begin
      tick();
      mem_ack = (i == 4); mem_rdata = 32'hDEAD_BEEF; #1;
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_data", instruction, 32'h0050_0093);
      chk("hold_req", 32'(mem_req), 32'd0);
    end

    // Zero-wait ack at 0x10.
    tick(); inst_addr = 32'h10; #1;
    chk("zw_miss", 32'(inst_valid), 32'd0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h1111_0010; #1;
    chk("zw_req", 32'(mem_req), 32'd1);
    chk("zw_addr", mem_addr, 32'h10);
    tick(); mem_ack = 1'b0; #1;
    chk("zw_valid", 32'(inst_valid), 32'd1);
    chk("zw_data", instruction, 32'h1111_0010);

    // Flush forces invalid, then an address switch mid-WAIT.
    tick(); flush = 1'b1; #1;
    chk("flush_force", 32'(inst_valid), 32'd0);
    tick(); flush = 1'b0; #1;
    chk("flush_empty", 32'(inst_valid), 32'd0);
    tick(); inst_addr = 32'h14; #1;
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_addr", mem_addr, 32'h10);
    chk("sw_valid", 32'(inst_valid), 32'd0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h2222_0010; #1;
    chk("sw_addr_stable", mem_addr, 32'h10);
    tick(); mem_ack = 1'b0; inst_addr = 32'h10; #1;
    chk("sw_fill_valid", 32'(inst_valid), 32'd1);
    chk("sw_fill_data", instruction, 32'h2222_0010);
    tick(); inst_addr = 32'h14; #1;
    chk("sw_miss14", 32'(inst_valid), 32'd0);
    chk("sw_idle", 32'(mem_req), 32'd0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h3333_0014; #1;
    chk("req14", 32'(mem_req), 32'd1);
    chk("req14_addr", mem_addr, 32'h14);
    tick(); mem_ack = 1'b0; #1;
    chk("fill14_valid", 32'(inst_valid), 32'd1);
    chk("fill14_data", instruction, 32'h3333_0014);

    // Timeout at 0x30 then retry.
    tick(); inst_addr = 32'h30; #1;
    chk("to_miss", 32'(inst_valid), 32'd0);
    for (int k = 0; k < int'(TO); k++) begin
      tick(); #1;
      chk("to_req_high", 32'(mem_req), 32'd1);
      chk("to_no_err", 32'(fetch_err), 32'd0);
    end
    tick(); #1;
    chk("to_req_low", 32'(mem_req), 32'd0);
    chk("to_err", 32'(fetch_err), 32'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h4444_0030; #1;
    chk("to_err_pulse", 32'(fetch_err), 32'd0);
    chk("retry_req", 32'(mem_req), 32'd1);
    chk("retry_addr", mem_addr, 32'h30);
    tick(); mem_ack = 1'b0; #1;
    chk("retry_valid", 32'(inst_valid), 32'd1);
    chk("retry_data", instruction, 32'h4444_0030);

    // Flush coincident with ack at 0x20: data dropped, re-request.
    tick(); inst_addr = 32'h20; #1;
    chk("fa_miss", 32'(inst_valid), 32'd0);
    tick(); mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h5555_0020; #1;
    chk("fa_req", 32'(mem_req), 32'd1);
    chk("fa_valid", 32'(inst_valid), 32'd0);
    tick(); mem_ack = 1'b0; flush = 1'b0; #1;
    chk("fa_dropped", 32'(inst_valid), 32'd0);
    chk("fa_idle", 32'(mem_req), 32'd0);
    tick(); mem_ack = 1'b1; #1;
    chk("fa_rereq", 32'(mem_req), 32'd1);
    chk("fa_rereq_addr", mem_addr, 32'h20);
    tick(); mem_ack = 1'b0; #1;
    chk("fa_fill_valid", 32'(inst_valid), 32'd1);
    chk("fa_fill_data", instruction, 32'h5555_0020);

    // Async reset mid-WAIT drops mem_req at once.
    tick(); inst_addr = 32'h50; #1;
    tick(); #1;
    chk("ar_req", 32'(mem_req), 32'd1);
    reset = 1'b1; #1;
    chk("ar_drop", 32'(mem_req), 32'd0);
    chk("ar_valid", 32'(inst_valid), 32'd0);
    tick(); reset = 1'b0;

    // Random traffic: bench acts as memory, model tracks buffer and request.
    m_v = 1'b0; m_busy = 1'b0; m_drop = 1'b0; m_err = 1'b0;
    m_addr = '0; m_req = '0; m_age = 0; m_lat = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) inst_addr = addr_tab[$urandom_range(0, 7)];
      m_fl  = ($urandom_range(0, 15) == 0);
      m_ack = m_busy ? (m_age == m_lat) : ($urandom_range(0, 7) == 0);
      flush = m_fl; mem_ack = m_ack;
      mem_rdata = m_busy ? memf(m_req) : $urandom;
      #1;
      m_word = {inst_addr[31:2], 2'b00};
      m_hit  = m_v && (m_addr == m_word);
      chk("rnd_valid", 32'(inst_valid), 32'(m_hit && !m_fl));
      if (m_hit && !m_fl) chk("rnd_data", instruction, memf(m_addr));
      chk("rnd_req", 32'(mem_req), 32'(m_busy));
      if (m_busy) chk("rnd_addr", mem_addr, m_req);
      chk("rnd_err", 32'(fetch_err), 32'(m_err));
      m_err = 1'b0;
      if (m_busy) begin
        if (m_ack) begin
          m_busy = 1'b0;
          if (!m_drop && !m_fl) begin
            m_v = 1'b1; m_addr = m_req;
          end
        end else if (m_age + 1 == int'(TO)) begin
          m_busy = 1'b0; m_err = 1'b1;
        end else begin
          m_age++;
        end
        if (m_fl) m_drop = 1'b1;
      end else if (!m_fl && !m_hit) begin
        m_busy = 1'b1; m_req = m_word; m_age = 0; m_drop = 1'b0;
        m_lat = ($urandom_range(0, 5) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      end
      if (m_fl) m_v = 1'b0;
      tick();
    end
    mem_ack = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
